// File: rtl/pipe_alu.sv
// pipe_alu - handshaked execute-stage ALU for the pipelined MIPS core.
//
// Logic ops, ADD/SUB and SLT finish in one cycle. MUL is an iterative
// shift-add that takes WIDTH cycles. Results are held in an output register,
// together with their zero and overflow flags, until the consumer accepts them.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous, active-low reset
//   in_valid   operand/opcode presented by the producer
//   in_ready   block can accept an operation this cycle
//   a, b       operands (WIDTH bits)
//   f          function code (3 bits)
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer accepts the result this cycle
//   y          result (WIDTH bits)
//   zero       y == 0
//   ovf        signed overflow of ADD/SUB, 0 for all other ops
module pipe_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] acc_next;
  logic             v;
  logic             lt;
  logic             is_mul;
  logic             accept;

  // A new op can be taken only in IDLE and only if the output register is
  // empty or being drained this cycle. Deliberately independent of in_valid.
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign is_mul   = (f == 3'b011);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath. f[2] turns the adder into a subtractor by
  // inverting b and injecting a carry. SLT uses sign ^ overflow so the
  // compare stays correct when the subtraction overflows.
  always_comb begin
    bb       = f[2] ? ~b : b;
    sum      = a + bb + {{(WIDTH-1){1'b0}}, f[2]};
    v        = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    lt       = sum[WIDTH-1] ^ v;
    acc_next = acc + (mplier[0] ? mcand : '0);
    res      = '0;
    case (f)
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b010:  res = sum;
      3'b100:  res = a & ~b;
      3'b101:  res = a | ~b;
      3'b110:  res = sum;
      3'b111:  res = {{(WIDTH-1){1'b0}}, lt};
      default: res = '0;
    endcase
  end

  // Control FSM and output register. In IDLE a drain and a load may happen in
  // the same cycle, in which case the load wins and out_valid stays high.
  // A MUL can only be accepted when the output register is free (or draining),
  // so the MUL state never has to wait for the consumer; on the last iteration
  // the final partial sum goes straight into the result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (is_mul) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= CW'(WIDTH-1);
              state  <= MUL;
            end else begin
              y         <= res;
              zero      <= (res == '0);
              ovf       <= (f[1:0] == 2'b10) && v;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_next;
          if (cnt == '0) begin
            y         <= acc_next;
            zero      <= (acc_next == '0);
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised, handshaked successor to the single-cycle datapath ALU, for the pipelined MIPS execute stage. Operands enter on a valid/ready handshake. Logic ops, add/sub and SLT complete in one cycle. MUL runs an iterative shift-add over WIDTH cycles. The result, zero flag and overflow flag are held in an output register until the consumer accepts them.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 4)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- f  in  3  function code
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts result this cycle
- y  out  WIDTH  result
- zero  out  1  y == 0
- ovf  out  1  signed overflow of ADD/SUB; 0 for all other ops

## Operation
- BB = f[2] ? ~b : b. Sum = a + BB + f[2], mod 2^WIDTH.
- Function codes:
  - 000 AND: a & b
  - 001 OR: a | b
  - 010 ADD: Sum
  - 011 MUL: low WIDTH bits of a*b; signed and unsigned give the same bits
  - 100: a & ~b
  - 101: a | ~b
  - 110 SUB: Sum
  - 111 SLT
- SLT result is {WIDTH-1 zeros, lt}, where lt = Sum[WIDTH-1] ^ V. V = (a[W-1] == BB[W-1]) && (Sum[W-1] != a[W-1]). This is a true signed compare, correct on overflow.
- ovf = V for 010 and 110; otherwise 0.
- zero and ovf are registered together with y and always describe the y currently presented.
- State machine: IDLE, MUL.
  - IDLE: in_ready = !out_valid || out_ready.
  - Non-MUL op accepted (in_valid && in_ready): result register loads; out_valid = 1 next cycle.
  - MUL op accepted: latch a (multiplicand, shifts left) and b (multiplier, shifts right); clear accumulator; load counter with WIDTH-1; go to MUL.
  - MUL: in_ready = 0. Each cycle, if multiplier[0] = 1, add multiplicand to accumulator (mod 2^WIDTH); then shift both registers.
  - MUL exit: when counter = 0, load the result register with the final accumulator value, set out_valid, return to IDLE. This happens on the last add cycle. Counter decrements otherwise.
  - MUL result transfer: if out_valid is still 1 from an earlier result, MUL does not start. in_ready already blocks acceptance, so an in-flight MUL always finds the result register free.
- Output register:
  - out_valid && out_ready with no new load: out_valid clears next cycle; y, zero and ovf retain their values.
  - Simultaneous drain and load (out_ready = 1, new op accepted): the new result replaces the old one and out_valid stays 1. Full throughput of one op per cycle for non-MUL ops.
  - out_valid && !out_ready: y, zero and ovf are stable and no new op is accepted.

## Timing
- Reset (reset_n = 0, asynchronous): state = IDLE, out_valid = 0, y = 0, zero = 0, ovf = 0, counter and accumulator cleared. in_ready = 1 while held in reset and after release.
- Reset mid-MUL aborts the operation; no result is produced.
- Non-MUL latency: accepted at edge k → out_valid, y, zero, ovf valid after edge k+1.
- MUL latency: accepted at edge k → in_ready = 0 from k+1 through the final MUL cycle; out_valid = 1 after edge k+WIDTH; in_ready = 1 again after edge k+WIDTH.
- in_valid without in_ready: inputs are ignored. The producer must hold them stable until accepted.
- Outputs are registered. in_ready is combinational from state, out_valid and out_ready only, never from in_valid.

## Test plan
- ADD, WIDTH = 32, a = 0x7FFFFFFF, b = 0x00000001, out_ready = 1 → one cycle later y = 0x80000000, ovf = 1, zero = 0.
- SUB a = 5, b = 5 → y = 0, zero = 1, ovf = 0. SUB a = 0x80000000, b = 1 → y = 0x7FFFFFFF, ovf = 1.
- SLT a = 0xFFFFFFFF, b = 1 → y = 1. SLT a = 0x7FFFFFFF, b = 0x80000000 → y = 0 (overflow case). Codes 100 and 101 with a = 0xF0F0F0F0, b = 0xFF00FF00 → y = 0x00F000F0 and 0xF0FFF0FF respectively.
- MUL a = 0x00010000, b = 0x00010001 → y = 0x00010000, out_valid exactly 32 cycles after accept, in_ready = 0 for cycles 1..31. MUL 0xFFFFFFFF × 0xFFFFFFFF → y = 0x00000001.
- Backpressure: back-to-back ADD(1,2) and OR(4,8) with out_ready = 0 → y = 3 held, in_ready = 0, OR not accepted. Raise out_ready → y = 0xC next cycle. Then hold out_ready = 1 with a continuous stream of ops → one result per cycle, no gaps.
- Assert reset_n = 0 during cycle 10 of a MUL → out_valid = 0, y = 0, in_ready = 1 immediately. After release a new ADD completes normally with 1-cycle latency.
